// File: rtl/alu_divider.sv
// alu_divider: multi-cycle restoring shift-subtract divider for the LEGv8
// datapath. Handles OPDIV, OPDIVU, OPREM and OPREMU; one quotient bit per
// cycle, MSB first, followed by a sign-fix cycle.
// Optional feature: define DIV_EARLY_OUT_EN to finish divide-by-zero, signed
// overflow and |iA| < |iB| requests on the accepting edge without iterating.
// The OP* parameters must match the codes in Parametros.v.
module alu_divider #(
   parameter int         WIDTH  = 64,
   parameter int         CNTW   = 6,
   parameter logic [4:0] OPDIV  = 5'b01010,
   parameter logic [4:0] OPDIVU = 5'b01011,
   parameter logic [4:0] OPREM  = 5'b01100,
   parameter logic [4:0] OPREMU = 5'b01101
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic [4:0]       iALUControl,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic [WIDTH-1:0] oResult,
   output logic             oBusy,
   output logic             oDone,
   output logic             oDivZero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;      // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
   logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
   logic [WIDTH-1:0] a_q, a_d;          // raw dividend, the remainder on divide-by-zero
   logic [WIDTH-1:0] result_q, result_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d;
   logic             is_rem_q, is_rem_d, dz_q, dz_d;
   logic             busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;

   logic             is_div_op, accept, op_signed, op_rem, early;
   logic [WIDTH-1:0] mag_a, mag_b, trial, q_fix, r_fix;
   logic             ge;

   // Decode the request and form operand magnitudes for signed ops
   always_comb begin
      is_div_op = (iALUControl == OPDIV)  || (iALUControl == OPDIVU) ||
                  (iALUControl == OPREM)  || (iALUControl == OPREMU);
      accept    = iStart && is_div_op && ((state_q == IDLE) || (state_q == DONE));
      op_signed = (iALUControl == OPDIV) || (iALUControl == OPREM);
      op_rem    = (iALUControl == OPREM) || (iALUControl == OPREMU);
      mag_a     = (op_signed && iA[WIDTH-1]) ? -iA : iA;
      mag_b     = (op_signed && iB[WIDTH-1]) ? -iB : iB;
   end

`ifdef DIV_EARLY_OUT_EN
   logic             ovf_case, zero_case, small_case;
   logic [WIDTH-1:0] early_res;

   // Detect requests whose result is known without iterating
   always_comb begin
      zero_case  = (iB == '0);
      ovf_case   = op_signed && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1);
      small_case = (mag_a < mag_b);
      early      = zero_case || ovf_case || small_case;
      if (zero_case)     early_res = op_rem ? iA : '1;
      else if (ovf_case) early_res = op_rem ? '0 : iA;
      else               early_res = op_rem ? iA : '0;
   end
`else
   assign early = 1'b0;
`endif

   // One restoring step; the carry bit covers partial remainders wider than WIDTH
   always_comb begin
      trial = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      ge    = rem_q[WIDTH-1] || (trial >= dvs_q);
      q_fix = qneg_q ? -quo_q : quo_q;
      r_fix = rneg_q ? -rem_q : rem_q;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: state_d = accept ? (early ? DONE : CALC) : IDLE;
         CALC:       if (cnt_q == '0) state_d = FIX;
         FIX:        state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      a_d       = a_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      is_rem_d  = is_rem_q;
      dz_d      = dz_q;
      result_d  = result_q;
      divzero_d = divzero_q;
      busy_d    = (state_d == CALC) || (state_d == FIX);
      done_d    = (state_d == DONE);
      if (accept) begin
         cnt_d    = CNTW'(WIDTH-1);
         quo_d    = mag_a;
         rem_d    = '0;
         dvs_d    = mag_b;
         a_d      = iA;
         qneg_d   = op_signed && (iA[WIDTH-1] ^ iB[WIDTH-1]);
         rneg_d   = op_signed && iA[WIDTH-1];
         is_rem_d = op_rem;
         dz_d     = (iB == '0);
`ifdef DIV_EARLY_OUT_EN
         if (early) begin
            result_d  = early_res;
            divzero_d = zero_case;
         end
`endif
      end else begin
         case (state_q)
            CALC: begin
               rem_d = ge ? (trial - dvs_q) : trial;
               quo_d = {quo_q[WIDTH-2:0], ge};
               cnt_d = cnt_q - CNTW'(1);
            end
            FIX: begin
               if (dz_q) result_d = is_rem_q ? a_q : '1;
               else      result_d = is_rem_q ? r_fix : q_fix;
               divzero_d = dz_q;
            end
            default: ;
         endcase
      end
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         a_q       <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         is_rem_q  <= 1'b0;
         dz_q      <= 1'b0;
         result_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values together.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         a_q       <= a_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         is_rem_q  <= is_rem_d;
         dz_q      <= dz_d;
         result_q  <= result_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign oResult  = result_q;
   assign oBusy    = busy_q;
   assign oDone    = done_q;
   assign oDivZero = divzero_q;

endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: randomized and directed checks of alu_divider against an
// arithmetic reference model (SV / and % with the special cases applied).
module tb_alu_divider;

   localparam logic [4:0] OPDIV  = 5'b01010;
   localparam logic [4:0] OPDIVU = 5'b01011;
   localparam logic [4:0] OPREM  = 5'b01100;
   localparam logic [4:0] OPREMU = 5'b01101;
   localparam logic [63:0] MINV  = 64'h8000_0000_0000_0000;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iStart;
   logic [4:0]  iALUControl;
   logic [63:0] iA, iB;
   logic [63:0] oResult;
   logic        oBusy, oDone, oDivZero;

   int checks = 0;
   int errors = 0;

   alu_divider #(.WIDTH(64), .CNTW(6)) dut (
      .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iALUControl(iALUControl),
      .iA(iA), .iB(iB), .oResult(oResult), .oBusy(oBusy), .oDone(oDone),
      .oDivZero(oDivZero)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic is_signed_op(input logic [4:0] op);
      return (op == OPDIV) || (op == OPREM);
   endfunction

   function automatic logic is_rem_op(input logic [4:0] op);
      return (op == OPREM) || (op == OPREMU);
   endfunction

   // Reference: {divzero, result}
   function automatic logic [64:0] model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
      longint sa, sb;
      logic [63:0] r;
      sa = a;
      sb = b;
      if (b == 64'd0) return {1'b1, is_rem_op(op) ? a : 64'hFFFF_FFFF_FFFF_FFFF};
      if (is_signed_op(op) && a == MINV && b == 64'hFFFF_FFFF_FFFF_FFFF)
         return {1'b0, is_rem_op(op) ? 64'd0 : a};
      if (is_signed_op(op)) r = is_rem_op(op) ? 64'(sa % sb) : 64'(sa / sb);
      else                  r = is_rem_op(op) ? a % b : a / b;
      return {1'b0, r};
   endfunction

   function automatic logic is_early(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_EARLY_OUT_EN
      logic [63:0] ma, mb;
      ma = (is_signed_op(op) && a[63]) ? -a : a;
      mb = (is_signed_op(op) && b[63]) ? -b : b;
      return (b == 64'd0) || (is_signed_op(op) && a == MINV && b == 64'hFFFF_FFFF_FFFF_FFFF) || (ma < mb);
`else
      return (op == 5'd31) && (a != a) && (b != b);
`endif
   endfunction

   // Count edges until oDone is seen; busy counts cycles with oBusy high
   task automatic wait_done(output int lat, output int busy_cyc);
      lat = 0;
      busy_cyc = 0;
      while (!oDone && lat < 200) begin
         @(posedge iCLK); #1;
         lat++;
         if (oBusy) busy_cyc++;
      end
   endtask

   // Issue one request at the next falling edge and check the whole transaction
   task automatic do_op(input string tag, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [64:0] exp;
      int lat, bc, busy0;
      logic early;
      exp   = model(op, a, b);
      early = is_early(op, a, b);
      @(negedge iCLK);
      iStart = 1'b1; iALUControl = op; iA = a; iB = b;
      @(posedge iCLK); #1;
      iStart = 1'b0; iA = {$urandom, $urandom}; iB = {$urandom, $urandom};
      busy0 = oBusy ? 1 : 0;
      wait_done(lat, bc);
      check({tag, ".result"}, oResult, exp[63:0]);
      check({tag, ".divzero"}, 64'(oDivZero), 64'(exp[64]));
      check({tag, ".latency"}, 64'(lat), early ? 64'd0 : 64'd65);
      check({tag, ".busy"}, 64'(busy0 + bc), early ? 64'd0 : 64'd65);
   endtask

   initial begin
      logic [4:0]  ops [4];
      logic [63:0] a, b;
      logic [64:0] exp1;
      int lat, bc;
      ops[0] = OPDIV; ops[1] = OPDIVU; ops[2] = OPREM; ops[3] = OPREMU;

      iRST = 1'b1; iStart = 1'b0; iALUControl = '0; iA = '0; iB = '0;
      #1;
      check("reset.result", oResult, 64'd0);
      check("reset.busy", 64'(oBusy), 64'd0);
      check("reset.done", 64'(oDone), 64'd0);
      check("reset.divzero", 64'(oDivZero), 64'd0);
      repeat (2) @(posedge iCLK);
      @(negedge iCLK); iRST = 1'b0;

      // Non-division opcode is ignored
      @(negedge iCLK); iStart = 1'b1; iALUControl = 5'b00010; iA = 64'd8; iB = 64'd2;
      @(posedge iCLK); #1; iStart = 1'b0;
      check("badop.busy", 64'(oBusy), 64'd0);
      check("badop.done", 64'(oDone), 64'd0);

      // Directed cases (each issued in the previous DONE cycle: back-to-back)
      do_op("div_100_7",   OPDIV,  64'd100,  64'd7);
      do_op("rem_m100_7",  OPREM,  -64'd100, 64'd7);
      do_op("divu_max_2",  OPDIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      do_op("div_5_0",     OPDIV,  64'd5,    64'd0);
      do_op("remu_5_0",    OPREMU, 64'd5,    64'd0);
      do_op("rem_m5_0",    OPREM,  -64'd5,   64'd0);
      do_op("div_ovf",     OPDIV,  MINV,     64'hFFFF_FFFF_FFFF_FFFF);
      do_op("rem_ovf",     OPREM,  MINV,     64'hFFFF_FFFF_FFFF_FFFF);
      do_op("div_m7_2",    OPDIV,  -64'd7,   64'd2);
      do_op("div_small",   OPDIV,  64'd3,    -64'd10);

      // Randomized operations
      for (int i = 0; i < 16; i++) begin
         a = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       b = {$urandom, $urandom};
            1:       b = ($urandom_range(0, 1) != 0) ? -64'($urandom_range(1, 1000)) : 64'($urandom_range(1, 1000));
            2:       b = 64'd0;
            default: b = a >> $urandom_range(1, 40);
         endcase
         do_op($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], a, b);
      end

      // iStart during CALC is ignored; oDone is a single-cycle pulse
      exp1 = model(OPDIV, 64'd1000, 64'd3);
      @(negedge iCLK); iStart = 1'b1; iALUControl = OPDIV; iA = 64'd1000; iB = 64'd3;
      @(posedge iCLK); #1; iStart = 1'b0;
      repeat (10) @(posedge iCLK);
      @(negedge iCLK); iStart = 1'b1; iALUControl = OPDIVU; iA = 64'd77; iB = 64'd1;
      @(posedge iCLK); #1; iStart = 1'b0;
      wait_done(lat, bc);
      check("ignore.result", oResult, exp1[63:0]);
      check("ignore.latency", 64'(lat + 11), 64'd65);
      @(posedge iCLK); #1;
      check("ignore.done_pulse", 64'(oDone), 64'd0);
      check("ignore.hold", oResult, exp1[63:0]);

      // Reset mid-CALC aborts with no oDone
      @(negedge iCLK); iStart = 1'b1; iALUControl = OPDIV; iA = 64'd123456; iB = 64'd11;
      @(posedge iCLK); #1; iStart = 1'b0;
      repeat (30) @(posedge iCLK);
      #2 iRST = 1'b1;
      #1;
      check("abort.result", oResult, 64'd0);
      check("abort.busy", 64'(oBusy), 64'd0);
      check("abort.done", 64'(oDone), 64'd0);
      check("abort.divzero", 64'(oDivZero), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge iCLK); #1;
         check("abort.no_done", 64'(oDone), 64'd0);
      end
      @(negedge iCLK); iRST = 1'b0;
      do_op("divu_9_3", OPDIVU, 64'd9, 64'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
